// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state, op and ALU function encodings for the multiply/divide sequencer
package muldiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU = 1'b1;
  localparam logic [4:0] ALUFN_ADD = 5'b00001;
  localparam logic [4:0] ALUFN_SUB = 5'b10001;
endpackage

// File: rtl/muldiv_seq_alu.sv
// ALU: datapath ALU; fn[1:0]=01 add/sub (fn[4] subtracts), 10 boolean (fn[3:2] selects), 00 passes B
module ALU #(
  parameter int N = 32
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [4:0]   ALUfn,
  output logic [N-1:0] R,
  output logic         FlagZ
);
  logic [N-1:0] arith, bool_r;
  always_comb begin
    arith = A + (ALUfn[4] ? ~B : B) + {{(N-1){1'b0}}, ALUfn[4]};
    bool_r = ALUfn[3] ? (ALUfn[2] ? ~(A | B) : A ^ B) : (ALUfn[2] ? A | B : A & B);
    R = ALUfn[1:0] == 2'b01 ? arith : ALUfn[1:0] == 2'b10 ? bool_r : B;
    FlagZ = R == '0;
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned MULTU (shift-add) / DIVU (restoring) sequencer producing HI/LO
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);
  localparam int CW = $clog2(N) + 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic op_q, op_d;
  logic [N-1:0] m_q, m_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, hi_q, hi_d, lo_q, lo_d;
  logic [N:0] s, alu_a, alu_b, alu_r, sum;
  logic [4:0] alu_fn;
  logic alu_z;
  logic [N-1:0] it_hi, it_lo;
  // m_q holds whichever operand the ALU consumes: multiplicand for MULTU, divisor for DIVU
  assign s = {acc_hi_q, acc_lo_q[N-1]};
  assign alu_a = op_q ? s : {1'b0, acc_hi_q};
  assign alu_b = {1'b0, m_q};
  assign alu_fn = op_q ? ALUFN_SUB : ALUFN_ADD;
  ALU #(.N(N + 1)) u_alu (
    .A(alu_a),
    .B(alu_b),
    .ALUfn(alu_fn),
    .R(alu_r),
    .FlagZ(alu_z)
  );
  assign sum = acc_lo_q[0] ? alu_r : {1'b0, acc_hi_q};
  assign it_hi = op_q ? (alu_r[N] ? s[N-1:0] : alu_r[N-1:0]) : sum[N:1];
  assign it_lo = op_q ? {acc_lo_q[N-2:0], ~alu_r[N]} : {sum[0], acc_lo_q[N-1:1]};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    m_d = m_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == IDLE && start) begin
      op_d = op;
      m_d = op == OP_DIVU ? b : a;
      acc_hi_d = '0;
      acc_lo_d = op == OP_DIVU ? a : b;
      cnt_d = CW'(N);
      state_d = (op == OP_DIVU && b == '0) ? DONE : RUN;
      hi_d = (op == OP_DIVU && b == '0) ? a : hi_q;
      lo_d = (op == OP_DIVU && b == '0) ? '1 : lo_q;
    end else if (state_q == RUN) begin
      acc_hi_d = it_hi;
      acc_lo_d = it_lo;
      cnt_d = cnt_q - 1'b1;
      state_d = cnt_q == CW'(1) ? DONE : RUN;
      hi_d = cnt_q == CW'(1) ? it_hi : hi_q;
      lo_d = cnt_q == CW'(1) ? it_lo : lo_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= 1'b0;
      m_q <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      m_q <= m_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table-driven MULTU/DIVU vectors plus start-while-busy and reset-abort sequences
module tb_muldiv_seq;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, op = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy, done;
  logic [31:0] hi, lo, prev_hi, prev_lo;
  int n_pass = 0, n_chk = 0;

  muldiv_seq #(.N(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;
  vec_t v[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_done(output int n, output logic ok_busy, output logic ok_hold);
    n = 0;
    ok_busy = 1'b1;
    ok_hold = 1'b1;
    while (done !== 1'b1 && n < 100) begin
      if (busy !== 1'b1) ok_busy = 1'b0;
      if (hi !== prev_hi || lo !== prev_lo) ok_hold = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    if (busy !== 1'b1) ok_busy = 1'b0;
  endtask

  task automatic finish_op(input string tag, input int n, input logic ok_busy, input logic ok_hold,
                           input logic [31:0] eh, input logic [31:0] el, input int lat);
    check({tag, " latency"}, n, lat);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    check({tag, " busy throughout"}, {31'b0, ok_busy}, 32'd1);
    check({tag, " hi/lo held during run"}, {31'b0, ok_hold}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, " done one cycle"}, {30'b0, done, busy}, 32'd0);
    check({tag, " result holds"}, hi ^ lo, eh ^ el);
    prev_hi = eh;
    prev_lo = el;
  endtask

  task automatic run_op(input string tag, input logic o, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] eh, input logic [31:0] el, input int lat);
    int n;
    logic ok_busy, ok_hold;
    @(negedge clk);
    op = o;
    a = xa;
    b = xb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, ok_busy, ok_hold);
    finish_op(tag, n, ok_busy, ok_hold, eh, el, lat);
  endtask

  initial begin
    int n;
    logic ok_busy, ok_hold;
    v[0] = '{1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 32};
    v[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32};
    v[2] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 32};
    v[3] = '{1'b0, 32'h80000000, 32'd2, 32'h00000001, 32'h00000000, 32};
    v[4] = '{1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 32};
    v[5] = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 32};
    v[6] = '{1'b1, 32'd5, 32'd9, 32'd5, 32'd0, 32};
    v[7] = '{1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 32};
    v[8] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 32};
    v[9] = '{1'b1, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 0};
    #3;
    check("reset outputs", {busy, done, 30'b0} | hi | lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    prev_hi = '0;
    prev_lo = '0;
    for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), v[i].op, v[i].a, v[i].b, v[i].hi, v[i].lo, v[i].lat);
    // a second start mid-run must not disturb the multiply in flight
    @(negedge clk);
    op = 1'b0;
    a = 32'd7;
    b = 32'd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    op = 1'b1;
    a = 32'd9;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, ok_busy, ok_hold);
    finish_op("busy_start", n + 6, ok_busy, ok_hold, 32'd0, 32'd42, 32);
    run_op("after_done", 1'b1, 32'd9, 32'd3, 32'd0, 32'd3, 32);
    @(negedge clk);
    op = 1'b0;
    a = 32'd11;
    b = 32'd13;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset mid-run busy/done", {30'b0, busy, done}, 32'd0);
    check("reset mid-run hi", hi, 32'd0);
    check("reset mid-run lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    prev_hi = '0;
    prev_lo = '0;
    run_op("post_reset", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 32);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative unsigned multiply/divide sequencer for the MIPS datapath. It produces the HI/LO results for MULTU and DIVU by driving a single internal ALU instance once per cycle: ADD for shift-add multiply, SUB for restoring divide. The block sits beside the main ALU in the execute stage and stalls the pipeline through `busy` until `done`.

## Interface
- `N`, default 32: operand width. Must be ≥ 2.
- `clk`, in, 1: clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: launch an operation. Sampled only in IDLE.
- `op`, in, 1: operation select. 0 = MULTU, 1 = DIVU.
- `a`, in, N: multiplicand / dividend. Captured on accepted `start`.
- `b`, in, N: multiplier / divisor. Captured on accepted `start`.
- `busy`, out, 1: high in RUN and DONE.
- `done`, out, 1: one-cycle pulse when `hi`/`lo` become valid.
- `hi`, out, N: MULTU gives product[2N-1:N]; DIVU gives remainder.
- `lo`, out, N: MULTU gives product[N-1:0]; DIVU gives quotient.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - `start`=1 captures `a`, `b` and `op`, then goes to RUN.
  - The iteration counter loads N.
  - Divide by zero (`op`=1, `b`=0) goes directly to DONE with `hi`=`a` and `lo`=all ones. No iterations run.
- **RUN, one iteration per cycle:**
  - The counter decrements each cycle.
  - The FSM leaves RUN for DONE on the cycle the counter goes 1→0.
- **ALU usage:**
  - The ALU is instantiated at width N+1.
  - Operands are zero-extended, so bit N of R is the carry (ADD) or the borrow (SUB).
  - `ALUfn` is only ever ALUFN_ADD or ALUFN_SUB.
  - FlagZ is unused.
- **MULTU (shift-add):**
  - Registers: acc_hi (N), acc_lo (N). acc_lo is initialised to `b`.
  - Each cycle: if acc_lo[0]=1, sum = ALU(ADD, {0,acc_hi}, {0,a}); otherwise sum = {0,acc_hi}.
  - Then {acc_hi, acc_lo} ← {sum[N:0], acc_lo[N-1:1]}, i.e. a 2N+1-bit right shift.
- **DIVU (restoring):**
  - Registers: rem (N), quo (N). quo is initialised to `a`; rem is initialised to 0.
  - Each cycle, shift: s = {rem[N-1:0], quo[N-1]}, held N+1 bits wide.
  - Trial: t = ALU(SUB, s, {0,b}).
  - If t[N]=0: rem ← t[N-1:0], quo ← {quo[N-2:0], 1}.
  - Otherwise: rem ← s[N-1:0], quo ← {quo[N-2:0], 0}.
- **DONE:**
  - `hi`/`lo` output registers load from the accumulators. They are already loaded for divide-by-zero.
  - `done`=1 for exactly this cycle, then the FSM returns to IDLE.
- **Result holding:** `hi`/`lo` hold their value until the next DONE. They are never disturbed during RUN.
- **`start` while busy:** ignored. No queueing.
- **`start` in the cycle after DONE:** accepted normally (the FSM is in IDLE).

## Timing
- **Reset:**
  - state = IDLE.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - Accumulators and counter = 0.
- **Reset mid-operation:** aborts immediately and asynchronously. The outputs take their reset values and the partial result is discarded.
- **Latency:**
  - `start` accepted at edge k.
  - RUN covers edges k+1 … k+N.
  - `done`=1 during the cycle after edge k+N. Results are registered at the edge entering DONE, so they are visible together with `done`.
  - Divide by zero: `done` is high in the cycle after edge k.
- **Throughput:** one operation per N+2 cycles when back-to-back (IDLE → RUN ×N → DONE → IDLE).
- **`busy`:** registered; goes to 1 in the cycle after `start` is accepted.
- **`op`, `a`, `b`:** don't-care except in the `start` cycle while in IDLE.
- **Combinational path:** one ALU evaluation per cycle (N+1-bit add/sub). No other long paths.

## Structure
- **Package `muldiv_pkg`:**
  - typedef enum logic [1:0] state_t {IDLE, RUN, DONE}.
  - Op encodings OP_MULTU=1'b0, OP_DIVU=1'b1.
  - ALUFN_ADD=5'b00001, ALUFN_SUB=5'b10001.
- **Sub-module:** one instance of the existing `ALU` with parameter N+1. No other sub-modules.
- **Counter width:** $clog2(N)+1 bits.

## Test plan
- **MULTU small:** `a`=7, `b`=6 → `hi`=0, `lo`=42. `done` lands exactly N+1 cycles after `start`; `busy` is high throughout.
- **MULTU max:** `a`=`b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001 (checks the carry into bit N).
- **DIVU:** `a`=100, `b`=7 → `lo`=14, `hi`=2. Also `a`=5, `b`=9 → `lo`=0, `hi`=5.
- **Divide by zero:** `a`=0x1234, `b`=0 → `done` in the cycle after `start`, `hi`=0x1234, `lo`=0xFFFFFFFF.
- **Start while busy:** pulse `start` with new operands mid-RUN → ignored; the original result completes unchanged. A `start` in the first IDLE cycle after `done` is accepted.
- **Reset mid-RUN:** assert `reset` at iteration 10 → `busy`/`done`/`hi`/`lo` are 0 immediately. A following 3×4 gives `lo`=12.
